// File: rtl/mac_kbd_pkg.sv
// rtl/mac_kbd_pkg.sv - shared types and default timing for the Mac keyboard serial link
package mac_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX         = 3'd1,
        CMD        = 3'd2,
        WAIT_REPLY = 3'd3,
        TX_WAIT    = 3'd4,
        TX         = 3'd5
    } state_t;

    localparam int HALF_W = 16;
    localparam int TO_W   = 21;

    localparam int unsigned CMD_HALF_DEF      = 1600;
    localparam int unsigned REPLY_HALF_DEF    = 720;
    localparam int unsigned START_DLY_DEF     = 16;
    localparam int unsigned REPLY_TIMEOUT_DEF = 1100000;

endpackage

// File: rtl/mac_kbd_serial_if.sv
// rtl/mac_kbd_serial_if.sv - byte/strobe link between the serial layer and the protocol core
interface mac_kbd_serial_if;

    logic [7:0] cmd_data;
    logic       cmd_strobe;
    logic [7:0] reply_data;
    logic       reply_strobe;
    logic       reply_drop;

    // master: the serial link layer; slave: the keyboard protocol core side
    modport master (
        output cmd_data, cmd_strobe, reply_drop,
        input  reply_data, reply_strobe
    );

    modport slave (
        input  cmd_data, cmd_strobe, reply_drop,
        output reply_data, reply_strobe
    );

endinterface

// File: rtl/mac_kbd_bitclk.sv
// rtl/mac_kbd_bitclk.sv - 8-period keyboard clock generator shared by command and reply frames
module mac_kbd_bitclk
    import mac_kbd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              start,
    input  logic [HALF_W-1:0] half,
    output logic              kbd_clk,
    output logic              rise,
    output logic              fall,
    output logic              done
);

    logic              active_q, active_d;
    logic              clk_q, clk_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic              phase_end;

    // rise/fall/done are flagged on the tick that flips the clock flop so the
    // parent can sample or drive data in lockstep with the registered edge
    assign phase_end = active_q && (cnt_q == (half - HALF_W'(1)));
    assign rise      = ce && phase_end && !clk_q;
    assign fall      = ce && phase_end && clk_q && (bit_q != 3'd7);
    assign done      = ce && phase_end && clk_q && (bit_q == 3'd7);
    assign kbd_clk   = clk_q;

    // phase counter and clock level; a frame opens with the low phase of bit 7
    always_comb begin
        active_d = active_q;
        clk_d    = clk_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        if (ce) begin
            if (start) begin
                active_d = 1'b1;
                clk_d    = 1'b0;
                cnt_d    = '0;
                bit_d    = 3'd0;
            end else if (active_q) begin
                if (phase_end) begin
                    cnt_d = '0;
                    clk_d = !clk_q;
                    if (clk_q) begin
                        if (bit_q == 3'd7) begin
                            active_d = 1'b0;
                            clk_d    = 1'b1;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + HALF_W'(1);
                end
            end
        end
    end

    // clock generator state register, idles with the clock released high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            clk_q    <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
        end else begin
            active_q <= active_d;
            clk_q    <= clk_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
        end
    end

endmodule

// File: rtl/mac_kbd_serial.sv
// rtl/mac_kbd_serial.sv - Mac keyboard serial link layer: command receive, reply transmit
module mac_kbd_serial
    import mac_kbd_pkg::*;
#(
    parameter int unsigned CMD_HALF      = CMD_HALF_DEF,
    parameter int unsigned REPLY_HALF    = REPLY_HALF_DEF,
    parameter int unsigned START_DLY     = START_DLY_DEF,
    parameter int unsigned REPLY_TIMEOUT = REPLY_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             mac_data,
    output logic             kbd_clk,
    output logic             kbd_data,
    output logic             busy,
    mac_kbd_serial_if.master kbd_if
);

    logic              sync1_q, sync2_q, mac_s;
    state_t            state_q, state_d;
    logic [HALF_W-1:0] start_cnt_q, start_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic              cmd_strobe_q, cmd_strobe_d;
    logic              kbd_data_q, kbd_data_d;
    logic              reply_drop_q, reply_drop_d;
    logic              bc_start, bc_rise, bc_fall, bc_done;
    logic [HALF_W-1:0] bc_half;

    assign mac_s                = sync2_q;
    assign busy                 = (state_q != IDLE);
    assign kbd_data             = kbd_data_q;
    assign kbd_if.cmd_data      = cmd_data_q;
    assign kbd_if.cmd_strobe    = cmd_strobe_q;
    assign kbd_if.reply_drop    = reply_drop_q;
    assign bc_half              = ((state_q == TX_WAIT) || (state_q == TX)) ?
                                  HALF_W'(REPLY_HALF) : HALF_W'(CMD_HALF);

    mac_kbd_bitclk u_bitclk (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .start   (bc_start),
        .half    (bc_half),
        .kbd_clk (kbd_clk),
        .rise    (bc_rise),
        .fall    (bc_fall),
        .done    (bc_done)
    );

    // two-flop guard for the Mac data line, clocked every clk regardless of ce
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= mac_data;
            sync2_q <= sync1_q;
        end
    end

    // frame sequencing: start detect, command shift-in, reply wait, reply shift-out
    always_comb begin
        state_d      = state_q;
        start_cnt_d  = start_cnt_q;
        to_cnt_d     = to_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        cmd_data_d   = cmd_data_q;
        cmd_strobe_d = cmd_strobe_q;
        kbd_data_d   = kbd_data_q;
        reply_drop_d = reply_drop_q;
        bc_start     = 1'b0;
        if (ce) begin
            cmd_strobe_d = 1'b0;
            reply_drop_d = kbd_if.reply_strobe && (state_q != WAIT_REPLY);
            case (state_q)
                IDLE: begin
                    kbd_data_d = 1'b1;
                    if (start_cnt_q == HALF_W'(START_DLY)) begin
                        state_d     = RX;
                        start_cnt_d = '0;
                        rx_shift_d  = '0;
                        bc_start    = 1'b1;
                    end else if (!mac_s) begin
                        start_cnt_d = start_cnt_q + HALF_W'(1);
                    end else begin
                        start_cnt_d = '0;
                    end
                end
                RX: begin
                    if (bc_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], mac_s};
                    end
                    if (bc_done) begin
                        cmd_data_d   = rx_shift_q;
                        cmd_strobe_d = 1'b1;
                        state_d      = CMD;
                    end
                end
                CMD: begin
                    state_d  = WAIT_REPLY;
                    to_cnt_d = '0;
                end
                WAIT_REPLY: begin
                    // a strobe wins over a timeout landing on the same tick
                    if (kbd_if.reply_strobe) begin
                        tx_shift_d = kbd_if.reply_data;
                        state_d    = TX_WAIT;
                    end else if (to_cnt_q == TO_W'(REPLY_TIMEOUT)) begin
                        state_d = IDLE;
                    end else if (to_cnt_q != {TO_W{1'b1}}) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                TX_WAIT: begin
                    if (mac_s) begin
                        state_d    = TX;
                        bc_start   = 1'b1;
                        kbd_data_d = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
                TX: begin
                    if (bc_fall) begin
                        kbd_data_d = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else if (bc_done) begin
                        kbd_data_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    kbd_data_d = 1'b1;
                end
            endcase
        end
    end

    // link state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            start_cnt_q  <= '0;
            to_cnt_q     <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            cmd_data_q   <= 8'h00;
            cmd_strobe_q <= 1'b0;
            kbd_data_q   <= 1'b1;
            reply_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_cnt_q  <= start_cnt_d;
            to_cnt_q     <= to_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            cmd_data_q   <= cmd_data_d;
            cmd_strobe_q <= cmd_strobe_d;
            kbd_data_q   <= kbd_data_d;
            reply_drop_q <= reply_drop_d;
        end
    end

endmodule

// File: tb/tb_mac_kbd_serial.sv
// tb/tb_mac_kbd_serial.sv - self-checking bench for mac_kbd_serial
module tb_mac_kbd_serial;

    localparam int CH = 4;
    localparam int RH = 3;
    localparam int SD = 5;
    localparam int TO = 60;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic mac_data = 1'b1;
    logic kbd_clk, kbd_data, busy;

    mac_kbd_serial_if kbd_if ();

    mac_kbd_serial #(
        .CMD_HALF      (CH),
        .REPLY_HALF    (RH),
        .START_DLY     (SD),
        .REPLY_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .mac_data (mac_data),
        .kbd_clk  (kbd_clk),
        .kbd_data (kbd_data),
        .busy     (busy),
        .kbd_if   (kbd_if)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         tk = 0;
    int         fall_t[$];
    int         rise_t[$];
    logic       rise_d[$];
    int         strobe_t[$];
    logic [7:0] strobe_v[$];
    int         drop_t[$];
    int         idle_t = -1;
    int         last_strobe = -1;
    logic       mac_bits[$];
    bit         mac_noise = 1'b0;
    logic       prev_clk = 1'b1;
    logic       prev_busy = 1'b0;

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        fall_t.delete(); rise_t.delete(); rise_d.delete();
        strobe_t.delete(); strobe_v.delete(); drop_t.delete();
        idle_t = -1;
    endtask

    // one ce tick preceded by >=2 idle clk cycles, then log edges like the Mac would see them
    task automatic tick();
        int gap;
        gap = $urandom_range(2, 3);
        repeat (gap) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        tk++;
        if (prev_clk && !kbd_clk) begin
            fall_t.push_back(tk);
            if (mac_bits.size() > 0) mac_data = mac_bits.pop_front();
        end
        if (!prev_clk && kbd_clk) begin
            rise_t.push_back(tk);
            rise_d.push_back(kbd_data);
        end
        if (kbd_if.cmd_strobe) begin
            strobe_t.push_back(tk);
            strobe_v.push_back(kbd_if.cmd_data);
        end
        if (kbd_if.reply_drop) drop_t.push_back(tk);
        if (prev_busy && !busy) idle_t = tk;
        if (mac_noise) mac_data = 1'($urandom);
        prev_clk  = kbd_clk;
        prev_busy = busy;
    endtask

    task automatic reset_check(input string where_);
        reset = 1'b1;
        #1;
        chk({where_, "_kbd_clk"}, kbd_clk, 1);
        chk({where_, "_kbd_data"}, kbd_data, 1);
        chk({where_, "_busy"}, busy, 0);
        chk({where_, "_cmd_strobe"}, kbd_if.cmd_strobe, 0);
        chk({where_, "_cmd_data"}, kbd_if.cmd_data, 0);
        chk({where_, "_reply_drop"}, kbd_if.reply_drop, 0);
        mac_data  = 1'b1;
        mac_noise = 1'b0;
        mac_bits.delete();
        kbd_if.reply_strobe = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        prev_clk  = 1'b1;
        prev_busy = 1'b0;
    endtask

    // Mac pulls data low, then presents each bit after every keyboard clock fall
    task automatic send_cmd(input logic [7:0] c, input int stop_falls);
        int         t_low, f0;
        logic [7:0] v;
        clear_logs();
        for (int i = 7; i >= 0; i--) mac_bits.push_back(c[i]);
        mac_data = 1'b0;
        t_low = tk;
        for (int n = 0; n < SD + 16 * CH + 20 && strobe_t.size() == 0 &&
             (stop_falls == 0 || fall_t.size() < stop_falls); n++) tick();
        if (stop_falls != 0) return;
        f0 = at(fall_t, 0);
        last_strobe = at(strobe_t, 0);
        v = (strobe_v.size() > 0) ? strobe_v[0] : 8'hxx;
        chk("cmd_start_latency", f0 - t_low, SD + 1);
        chk("cmd_rise_count", rise_t.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("cmd_fall_tick", at(fall_t, i), f0 + 2 * i * CH);
            chk("cmd_rise_tick", at(rise_t, i), f0 + (2 * i + 1) * CH);
        end
        chk("cmd_strobe_tick", last_strobe, f0 + 16 * CH);
        chk("cmd_data", v, c);
        tick();
        mac_data = 1'b1;
        chk("cmd_strobe_width", strobe_t.size(), 1);
        chk("cmd_data_hold", kbd_if.cmd_data, c);
    endtask

    task automatic do_reply(input logic [7:0] r, input int pre, input int hold_low,
                            input bit noise, input int stop_falls);
        int trel, f0;
        repeat (pre) tick();
        clear_logs();
        kbd_if.reply_data   = r;
        kbd_if.reply_strobe = 1'b1;
        tick();
        kbd_if.reply_strobe = 1'b0;
        kbd_if.reply_data   = 8'($urandom);
        if (hold_low > 0) begin
            mac_data = 1'b0;
            repeat (hold_low) tick();
            chk("txwait_no_edges", fall_t.size() + rise_t.size(), 0);
            chk("txwait_busy", busy, 1);
            chk("txwait_kbd_data", kbd_data, 1);
            mac_data = 1'b1;
        end
        trel = tk + 1;
        mac_noise = noise;
        for (int n = 0; n < 16 * RH + 10 && idle_t < 0 &&
             (stop_falls == 0 || fall_t.size() < stop_falls); n++) tick();
        mac_noise = 1'b0;
        mac_data  = 1'b1;
        if (stop_falls != 0) return;
        f0 = at(fall_t, 0);
        chk("tx_start_tick", f0, trel);
        chk("tx_rise_count", rise_t.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("tx_fall_tick", at(fall_t, i), f0 + 2 * i * RH);
            chk("tx_bit", (i < rise_d.size()) ? rise_d[i] : 1'bx, r[7 - i]);
        end
        chk("tx_end_tick", idle_t, f0 + 16 * RH);
        chk("tx_idle_kbd_data", kbd_data, 1);
        chk("tx_idle_kbd_clk", kbd_clk, 1);
        chk("tx_no_drop", drop_t.size(), 0);
    endtask

    task automatic check_timeout();
        clear_logs();
        for (int n = 0; n < TO + 10 && idle_t < 0; n++) tick();
        chk("timeout_idle_tick", idle_t, last_strobe + TO + 2);
        chk("timeout_kbd_clk", kbd_clk, 1);
        chk("timeout_kbd_data", kbd_data, 1);
        chk("timeout_no_edges", rise_t.size() + fall_t.size(), 0);
    endtask

    task automatic check_idle_drop();
        clear_logs();
        kbd_if.reply_data   = 8'($urandom);
        kbd_if.reply_strobe = 1'b1;
        tick();
        kbd_if.reply_strobe = 1'b0;
        chk("drop_pulse", kbd_if.reply_drop, 1);
        tick();
        chk("drop_clear", kbd_if.reply_drop, 0);
        chk("drop_kbd_data", kbd_data, 1);
        chk("drop_busy", busy, 0);
        chk("drop_count", drop_t.size(), 1);
    endtask

    initial begin
        kbd_if.reply_strobe = 1'b0;
        kbd_if.reply_data   = 8'h00;
        repeat (2) @(negedge clk);
        reset_check("por");
        repeat (3) tick();

        send_cmd(8'h10, 0);
        do_reply(8'($urandom), 1, 0, 1'b0, 0);
        send_cmd(8'h16, 0);
        do_reply(8'h03, 0, 0, 1'b0, 0);
        send_cmd(8'h55, 0);
        check_timeout();
        send_cmd(8'($urandom), 0);
        do_reply(8'($urandom), 3, 7, 1'b0, 0);
        check_idle_drop();

        send_cmd(8'($urandom), 4);
        reset_check("rx_bit4");
        repeat (2) tick();
        send_cmd(8'h14, 0);
        do_reply(8'($urandom), 0, 0, 1'b1, 0);

        send_cmd(8'($urandom), 0);
        do_reply(8'($urandom), 2, 0, 1'b0, 5);
        reset_check("tx_bit3");
        repeat (2) tick();
        send_cmd(8'h14, 0);
        do_reply(8'($urandom), 0, 2, 1'b0, 0);

        for (int k = 0; k < 3; k++) begin
            send_cmd(8'($urandom), 0);
            do_reply(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                     1'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
